// File: rtl/regwatch_checker.sv
// regwatch_checker: shadow register file plus checkpoint walker.
// Grades CPU test programs by snooping writeback and flag writes.
module regwatch_checker #(
  parameter int NUM_CHECKS        = 16,
  parameter int DATA_W            = 32,
  parameter int FLAG_REG          = 20,
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int PER_CHECK_TIMEOUT = 0,
  localparam int IW = (NUM_CHECKS < 2) ? 1 : $clog2(NUM_CHECKS),
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_en,
  input  logic [4:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_cfg_we,
  input  logic [IW-1:0]     i_cfg_idx,
  input  logic [DATA_W-1:0] i_cfg_flag,
  input  logic [4:0]        i_cfg_reg,
  input  logic [DATA_W-1:0] i_cfg_exp,
  input  logic [IW:0]       i_cfg_count,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_pass,
  output logic              o_fail,
  output logic              o_timeout,
  output logic              o_chk_valid,
  output logic [IW-1:0]     o_chk_idx,
  output logic [DATA_W-1:0] o_fail_got,
  output logic [DATA_W-1:0] o_fail_exp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [4:0]    FLAG_ADDR = 5'(FLAG_REG);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(TIMEOUT_CYCLES);
  localparam logic [IW:0]   NC_LIM    = (IW+1)'(NUM_CHECKS);

  state_t r_state, w_state_nx;

  logic [DATA_W-1:0] r_shadow [32];
  logic [DATA_W-1:0] r_tflag  [NUM_CHECKS];
  logic [4:0]        r_treg   [NUM_CHECKS];
  logic [DATA_W-1:0] r_texp   [NUM_CHECKS];

  logic [IW:0]       r_count, w_count_nx;
  logic [IW-1:0]     r_idx, w_idx_nx;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic              r_pass, w_pass_nx;
  logic              r_fail, w_fail_nx;
  logic              r_tmo, w_tmo_nx;
  logic              r_chk_valid, w_chk_valid_nx;
  logic [IW-1:0]     r_chk_idx, w_chk_idx_nx;
  logic [DATA_W-1:0] r_fail_got, w_fail_got_nx;
  logic [DATA_W-1:0] r_fail_exp, w_fail_exp_nx;

  logic              w_busy;
  logic              w_flag_hit;
  logic              w_match;
  logic              w_last;
  logic              w_expire;
  logic [DATA_W-1:0] w_cur_flag;
  logic [DATA_W-1:0] w_cur_exp;
  logic [DATA_W-1:0] w_cur_val;
  logic [CW-1:0]     w_cnt_dec;

  assign w_busy     = (r_state == S_WAIT) ||
                      (r_state == S_CHECK);
  assign w_cur_flag = r_tflag[r_idx];
  assign w_cur_exp  = r_texp[r_idx];
  assign w_cur_val  = r_shadow[r_treg[r_idx]];
  assign w_flag_hit = i_wb_en &&
                      (i_wb_addr == FLAG_ADDR) &&
                      (i_wb_data == w_cur_flag);
  assign w_match    = (w_cur_val == w_cur_exp);
  assign w_last     = (({1'b0, r_idx} + (IW+1)'(1)) == r_count);
  assign w_expire   = (r_cnt <= CW'(1));
  assign w_cnt_dec  = (r_cnt != '0) ? (r_cnt - CW'(1)) : '0;

  // Mirror architectural writes; x0 is never written so it reads 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
      r_shadow[i_wb_addr] <= i_wb_data;
    end
  end

  // Load checkpoint entries only between runs.
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && !w_busy &&
        ({1'b0, i_cfg_idx} < NC_LIM)) begin
      r_tflag[i_cfg_idx] <= i_cfg_flag;
      r_treg[i_cfg_idx]  <= i_cfg_reg;
      r_texp[i_cfg_idx]  <= i_cfg_exp;
    end
  end

  // Next state and result updates for the checkpoint walk.
  always_comb begin
    w_state_nx     = r_state;
    w_count_nx     = r_count;
    w_idx_nx       = r_idx;
    w_cnt_nx       = r_cnt;
    w_pass_nx      = r_pass;
    w_fail_nx      = r_fail;
    w_tmo_nx       = r_tmo;
    w_chk_valid_nx = 1'b0;
    w_chk_idx_nx   = r_chk_idx;
    w_fail_got_nx  = r_fail_got;
    w_fail_exp_nx  = r_fail_exp;
    unique case (r_state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (i_start) begin
          w_pass_nx     = 1'b0;
          w_fail_nx     = 1'b0;
          w_tmo_nx      = 1'b0;
          w_fail_got_nx = '0;
          w_fail_exp_nx = '0;
          w_chk_idx_nx  = '0;
          w_idx_nx      = '0;
          w_count_nx    = i_cfg_count;
          if (i_cfg_count == '0) begin
            w_state_nx = S_PASS;
            w_pass_nx  = 1'b1;
          end else begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nx     = w_cnt_dec;
        w_chk_idx_nx = r_idx;
        if (w_flag_hit) begin
          w_state_nx = S_CHECK;
        end else if (w_expire) begin
          w_state_nx = S_FAIL;
          w_fail_nx  = 1'b1;
          w_tmo_nx   = 1'b1;
        end
      end
      S_CHECK: begin
        w_cnt_nx     = w_cnt_dec;
        w_chk_idx_nx = r_idx;
        if (!w_match) begin
          w_state_nx    = S_FAIL;
          w_fail_nx     = 1'b1;
          w_fail_got_nx = w_cur_val;
          w_fail_exp_nx = w_cur_exp;
        end else begin
          w_chk_valid_nx = 1'b1;
          if (w_last) begin
            w_state_nx = S_PASS;
            w_pass_nx  = 1'b1;
          end else begin
            w_state_nx = S_WAIT;
            w_idx_nx   = r_idx + IW'(1);
            if (PER_CHECK_TIMEOUT != 0) begin
              w_cnt_nx = CNT_LOAD;
            end
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Commit state and results; reset aborts any run in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_tmo       <= 1'b0;
      r_chk_valid <= 1'b0;
      r_chk_idx   <= '0;
      r_fail_got  <= '0;
      r_fail_exp  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_idx       <= w_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_pass      <= w_pass_nx;
      r_fail      <= w_fail_nx;
      r_tmo       <= w_tmo_nx;
      r_chk_valid <= w_chk_valid_nx;
      r_chk_idx   <= w_chk_idx_nx;
      r_fail_got  <= w_fail_got_nx;
      r_fail_exp  <= w_fail_exp_nx;
    end
  end

  assign o_busy      = w_busy;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_timeout   = r_tmo;
  assign o_chk_valid = r_chk_valid;
  assign o_chk_idx   = r_chk_idx;
  assign o_fail_got  = r_fail_got;
  assign o_fail_exp  = r_fail_exp;

endmodule

// File: tb/tb_regwatch_checker.sv
// tb_regwatch_checker: directed and randomized checks of regwatch_checker.
// Three instances: default budget, and 50-cycle budgets with/without reload.
module tb_regwatch_checker;
  localparam int NC = 16;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int FR = 20;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_en = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [DW-1:0] cfg_flag = '0;
  logic [4:0] cfg_reg = '0;
  logic [DW-1:0] cfg_exp = '0;
  logic [IW:0] cfg_count = '0;
  logic start = 1'b0;

  logic a_busy, a_pass, a_fail, a_timeout, a_chk_valid;
  logic [IW-1:0] a_chk_idx;
  logic [DW-1:0] a_fail_got, a_fail_exp;
  logic b_busy, b_pass, b_fail, b_timeout, b_chk_valid;
  logic [IW-1:0] b_chk_idx;
  logic [DW-1:0] b_fail_got, b_fail_exp;
  logic c_busy, c_pass, c_fail, c_timeout, c_chk_valid;
  logic [IW-1:0] c_chk_idx;
  logic [DW-1:0] c_fail_got, c_fail_exp;

  regwatch_checker u_a (
    .i_clk(clk), .i_rst(rst),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_flag(cfg_flag),
    .i_cfg_reg(cfg_reg), .i_cfg_exp(cfg_exp),
    .i_cfg_count(cfg_count), .i_start(start),
    .o_busy(a_busy), .o_pass(a_pass), .o_fail(a_fail),
    .o_timeout(a_timeout), .o_chk_valid(a_chk_valid),
    .o_chk_idx(a_chk_idx), .o_fail_got(a_fail_got),
    .o_fail_exp(a_fail_exp)
  );

  regwatch_checker #(.TIMEOUT_CYCLES(50), .PER_CHECK_TIMEOUT(1)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_flag(cfg_flag),
    .i_cfg_reg(cfg_reg), .i_cfg_exp(cfg_exp),
    .i_cfg_count(cfg_count), .i_start(start),
    .o_busy(b_busy), .o_pass(b_pass), .o_fail(b_fail),
    .o_timeout(b_timeout), .o_chk_valid(b_chk_valid),
    .o_chk_idx(b_chk_idx), .o_fail_got(b_fail_got),
    .o_fail_exp(b_fail_exp)
  );

  regwatch_checker #(.TIMEOUT_CYCLES(50), .PER_CHECK_TIMEOUT(0)) u_c (
    .i_clk(clk), .i_rst(rst),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_flag(cfg_flag),
    .i_cfg_reg(cfg_reg), .i_cfg_exp(cfg_exp),
    .i_cfg_count(cfg_count), .i_start(start),
    .o_busy(c_busy), .o_pass(c_pass), .o_fail(c_fail),
    .o_timeout(c_timeout), .o_chk_valid(c_chk_valid),
    .o_chk_idx(c_chk_idx), .o_fail_got(c_fail_got),
    .o_fail_exp(c_fail_exp)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_shadow [32];
  logic [DW-1:0] m_flag [NC];
  logic [4:0]    m_reg  [NC];
  logic [DW-1:0] m_exp  [NC];
  int n_checks = 0;
  int n_fail = 0;
  int q_seen [$];

  always @(negedge clk) begin
    if (a_chk_valid === 1'b1) q_seen.push_back(int'(a_chk_idx));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [DW-1:0] d);
    wb_en = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    wb_en = 1'b0;
    if (a != 5'd0) m_shadow[a] = d;
  endtask

  task automatic cfg(input int i, input logic [DW-1:0] f,
                     input logic [4:0] r, input logic [DW-1:0] e);
    cfg_we = 1'b1;
    cfg_idx = i[IW-1:0];
    cfg_flag = f;
    cfg_reg = r;
    cfg_exp = e;
    step();
    cfg_we = 1'b0;
    m_flag[i] = f;
    m_reg[i] = r;
    m_exp[i] = e;
  endtask

  task automatic go(input int c);
    q_seen.delete();
    cfg_count = c[IW:0];
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a_busy, a_pass, a_fail, a_timeout, a_chk_valid,
         a_chk_idx, a_fail_got, a_fail_exp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b pass=%b fail=%b tmo=%b idx=%0d required all 0",
               a_busy, a_pass, a_fail, a_timeout, a_chk_idx);
    end
  endtask

  task automatic test_basic();
    cfg(0, 1, 5'd1, 300);
    cfg(1, 2, 5'd1, 'h40);
    go(2);
    n_checks++;
    if (a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy got %b required 1", a_busy);
    end
    wb(5'd1, 300); step();
    wb(5'(FR), 1); step();
    wb(5'd1, 'h40); step();
    wb(5'(FR), 2);
    n_checks++;
    if (a_pass !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_early got pass=%b busy=%b required 0/1", a_pass, a_busy);
    end
    step();
    n_checks++;
    if ({a_pass, a_fail, a_busy, a_chk_valid, a_chk_idx} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL basic_latency got pass=%b fail=%b busy=%b v=%b idx=%0d required 1 0 0 1 1",
               a_pass, a_fail, a_busy, a_chk_valid, a_chk_idx);
    end
    step();
    n_checks++;
    if (a_chk_valid !== 1'b0 || a_pass !== 1'b1 || q_seen.size() != 2 ||
        q_seen[0] != 0 || q_seen[1] != 1) begin
      n_fail++;
      $display("FAIL basic_pulses got v=%b pass=%b pulses=%0d required 0 1 2",
               a_chk_valid, a_pass, q_seen.size());
    end
  endtask

  task automatic test_mismatch();
    go(2);
    wb(5'd1, 301); step();
    wb(5'(FR), 1); step();
    n_checks++;
    if ({a_pass, a_fail, a_timeout, a_busy, a_chk_idx} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL mismatch_status got pass=%b fail=%b tmo=%b busy=%b idx=%0d required 0 1 0 0 0",
               a_pass, a_fail, a_timeout, a_busy, a_chk_idx);
    end
    n_checks++;
    if (a_fail_got !== m_shadow[m_reg[0]] || a_fail_exp !== m_exp[0]) begin
      n_fail++;
      $display("FAIL mismatch_values got %0d/%0d required %0d/%0d",
               a_fail_got, a_fail_exp, m_shadow[m_reg[0]], m_exp[0]);
    end
  endtask

  task automatic test_stray();
    bit ep;
    cfg(0, 1, 5'd1, 'h55);
    wb(5'd1, 'h55);
    go(1);
    cfg_we = 1'b1; cfg_idx = '0; cfg_flag = 9;
    step();
    cfg_we = 1'b0;
    cfg_count = '0; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1 || a_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy got busy=%b pass=%b required 1 0", a_busy, a_pass);
    end
    wb(5'(FR), 5); step(); step();
    n_checks++;
    if (a_busy !== 1'b1 || a_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_flag got busy=%b fail=%b required 1 0", a_busy, a_fail);
    end
    wb(5'(FR), 1); step(); step();
    ep = (m_shadow[m_reg[0]] == m_exp[0]);
    n_checks++;
    if (a_pass !== ep || q_seen.size() != 1 || q_seen[0] != 0) begin
      n_fail++;
      $display("FAIL stray_pass got pass=%b pulses=%0d required %b 1",
               a_pass, q_seen.size(), ep);
    end
  endtask

  task automatic test_x0();
    bit ep;
    cfg(0, 1, 5'd0, 0);
    wb(5'd0, 7);
    go(1);
    wb(5'(FR), 1); step();
    ep = (m_shadow[m_reg[0]] == m_exp[0]);
    n_checks++;
    if (a_pass !== ep || a_fail !== !ep) begin
      n_fail++;
      $display("FAIL x0_zero got pass=%b fail=%b required %b", a_pass, a_fail, ep);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    cfg(0, 7, 5'd3, 0);
    go(1);
    cyc = 0;
    while (a_fail !== 1'b1 && cyc < TMO + 100) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc != TMO) begin
      n_fail++;
      $display("FAIL timeout_cycles got %0d required %0d", cyc, TMO);
    end
    n_checks++;
    if ({a_timeout, a_pass, a_busy, a_fail_got, a_fail_exp} !==
        {1'b1, 1'b0, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL timeout_status got tmo=%b pass=%b busy=%b got=%0d exp=%0d required 1 0 0 0 0",
               a_timeout, a_pass, a_busy, a_fail_got, a_fail_exp);
    end
  endtask

  task automatic test_boundary();
    cfg(0, 6, 5'd4, 'habc);
    wb(5'd4, 'habc);
    go(1);
    repeat (49) step();
    wb(5'(FR), 6);
    step();
    n_checks++;
    if (c_pass !== 1'b1 || c_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_match_wins got pass=%b tmo=%b required 1 0", c_pass, c_timeout);
    end
    go(1);
    repeat (49) step();
    n_checks++;
    if (c_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_early got fail=%b required 0", c_fail);
    end
    step();
    n_checks++;
    if (c_fail !== 1'b1 || c_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_expire got fail=%b tmo=%b required 1 1", c_fail, c_timeout);
    end
    wb(5'(FR), 6); step();
  endtask

  task automatic test_per_check();
    cfg(0, 1, 5'd1, 'h11);
    cfg(1, 2, 5'd2, 'h22);
    cfg(2, 3, 5'd3, 'h33);
    wb(5'd1, 'h11); wb(5'd2, 'h22); wb(5'd3, 'h33);
    go(3);
    for (int k = 1; k <= 3; k++) begin
      repeat (39) step();
      wb(5'(FR), DW'(k));
    end
    step();
    n_checks++;
    if (b_pass !== 1'b1 || b_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL per_check_reload got pass=%b fail=%b required 1 0", b_pass, b_fail);
    end
    n_checks++;
    if (c_fail !== 1'b1 || c_timeout !== 1'b1 || c_chk_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL per_run_budget got fail=%b tmo=%b idx=%0d required 1 1 1",
               c_fail, c_timeout, c_chk_idx);
    end
    n_checks++;
    if (a_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL per_check_main got pass=%b required 1", a_pass);
    end
  endtask

  task automatic test_reset_mid();
    bit ep;
    cfg(0, 1, 5'd1, 0);
    wb(5'd1, 'h99);
    go(1);
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
    n_checks++;
    if ({a_busy, a_pass, a_fail, a_timeout, a_chk_valid, a_chk_idx,
         a_fail_got, a_fail_exp, b_busy, c_busy, c_fail} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b pass=%b fail=%b tmo=%b required all 0",
               a_busy, a_pass, a_fail, a_timeout);
    end
    go(1);
    wb(5'(FR), 1); step();
    ep = (m_shadow[m_reg[0]] == m_exp[0]);
    n_checks++;
    if (a_pass !== ep || a_fail !== !ep) begin
      n_fail++;
      $display("FAIL reset_rerun got pass=%b fail=%b required %b", a_pass, a_fail, ep);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int cnt;
      int idx;
      int gap;
      bit done;
      bit ep;
      bit ef;
      bit ok;
      logic [DW-1:0] eg;
      logic [DW-1:0] ee;
      logic [4:0] wa [$];
      logic [DW-1:0] wd [$];
      logic [DW-1:0] sh [32];
      int eq [$];
      wa.delete();
      wd.delete();
      eq.delete();
      cnt = $urandom_range(1, 4);
      for (int k = 0; k < cnt; k++) begin
        int rr;
        rr = $urandom_range(0, 4);
        cfg(k, DW'($urandom_range(1, 6)),
            (rr == 4) ? 5'(FR) : 5'(rr),
            DW'($urandom_range(0, 3)));
      end
      for (int k = 0; k < cnt; k++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          if ($urandom_range(0, 7) == 0) begin
            wa.push_back(5'(FR));
            wd.push_back(DW'($urandom_range(0, 7)));
          end else begin
            wa.push_back(5'($urandom_range(0, 3)));
            wd.push_back(DW'($urandom_range(0, 3)));
          end
        end
        if ($urandom_range(0, 3) != 0) begin
          wa.push_back(m_reg[k]);
          wd.push_back(m_exp[k]);
        end
        wa.push_back(5'(FR));
        wd.push_back(m_flag[k]);
      end
      for (int i = 0; i < 32; i++) sh[i] = m_shadow[i];
      idx = 0; done = 0; ep = 0; ef = 0; eg = '0; ee = '0;
      for (int w = 0; w < wa.size(); w++) begin
        if (!done) begin
          if (wa[w] != 5'd0) sh[wa[w]] = wd[w];
          if (wa[w] == 5'(FR) && wd[w] == m_flag[idx]) begin
            if (sh[m_reg[idx]] == m_exp[idx]) begin
              eq.push_back(idx);
              if (idx == cnt - 1) begin
                done = 1; ep = 1;
              end else begin
                idx++;
              end
            end else begin
              done = 1; ef = 1;
              eg = sh[m_reg[idx]];
              ee = m_exp[idx];
            end
          end
        end
      end
      go(cnt);
      for (int w = 0; w < wa.size(); w++) begin
        wb(wa[w], wd[w]);
        gap = $urandom_range(1, 2);
        repeat (gap) step();
      end
      step();
      n_checks++;
      if ({a_pass, a_fail, a_timeout, a_busy} !== {ep, ef, 1'b0, !done}) begin
        n_fail++;
        $display("FAIL rand_status it=%0d got p=%b f=%b t=%b b=%b required %b %b 0 %b",
                 it, a_pass, a_fail, a_timeout, a_busy, ep, ef, !done);
      end
      if (done) begin
        n_checks++;
        if (a_chk_idx !== IW'(idx) || a_fail_got !== eg || a_fail_exp !== ee) begin
          n_fail++;
          $display("FAIL rand_result it=%0d got idx=%0d got=%0d exp=%0d required %0d %0d %0d",
                   it, a_chk_idx, a_fail_got, a_fail_exp, idx, eg, ee);
        end
      end
      ok = (q_seen.size() == eq.size());
      if (ok) begin
        foreach (eq[i]) if (q_seen[i] != eq[i]) ok = 0;
      end
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_pulses it=%0d got %0d pulses required %0d",
                 it, q_seen.size(), eq.size());
      end
      if (!done) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_stray();
    test_x0();
    test_timeout();
    test_boundary();
    test_per_check();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
